alu_result_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_result_stage_flag_gen.sv | 29 ++
 rtl/alu_result_stage.sv | 133 +++++++++++++
 tb/tb_alu_result_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions, the
// per-entry flag metadata, and the occupancy states of the skid buffer.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    // Bit positions inside a {Z,N,C,V} nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flag metadata captured with each result. keep_cv means C/V are taken
    // from the status register when the entry is presented/retired.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic keep_cv;
        logic flag_we;
    } flag_meta_t;

    // Full buffer entry at the default datapath width
    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        flag_meta_t           meta;
    } entry_t;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational flag derivation for an incoming ALU result. C/V are only
// meaningful for arithmetic ops; logical ops either clear them or defer to
// the status register via keep_cv.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH        = ALU_WIDTH,
    parameter bit LOGIC_CLR_CV = 1'b1
) (
    input  logic [WIDTH-1:0] X,
    input  logic             CIN_ALU,
    input  logic             VIN_ALU,
    input  logic             IS_ARITH,
    input  logic             FLAG_WE,
    output flag_meta_t       meta_o
);

    // Z/N from the full-width result, C/V gated by the op class
    always_comb begin
        meta_o         = '0;
        meta_o.z       = (X == '0);
        meta_o.n       = X[WIDTH-1];
        meta_o.c       = IS_ARITH & CIN_ALU;
        meta_o.v       = IS_ARITH & VIN_ALU;
        meta_o.keep_cv = ~IS_ARITH & ~LOGIC_CLR_CV;
        meta_o.flag_we = FLAG_WE;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer (head + skid) feeding
// writeback through valid/ready, plus the architectural status register.
// in_ready is registered, so there is no combinational path from out_ready.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH        = ALU_WIDTH,
    parameter bit LOGIC_CLR_CV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] X,
    input  logic             CIN_ALU,
    input  logic             VIN_ALU,
    input  logic             IS_ARITH,
    input  logic             FLAG_WE,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] R,
    output logic [3:0]       FLAGS,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       SR
);

    flag_meta_t       in_meta;
    occ_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    flag_meta_t       meta_q [2];
    flag_meta_t       meta_d [2];
    logic [3:0]       sr_q, sr_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, retire;
    logic [3:0]       head_flags;

    alu_flag_gen #(
        .WIDTH        (WIDTH),
        .LOGIC_CLR_CV (LOGIC_CLR_CV)
    ) u_flag_gen (
        .X        (X),
        .CIN_ALU  (CIN_ALU),
        .VIN_ALU  (VIN_ALU),
        .IS_ARITH (IS_ARITH),
        .FLAG_WE  (FLAG_WE),
        .meta_o   (in_meta)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign retire    = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign R         = data_q[0];
    assign FLAGS     = head_flags;
    assign SR        = sr_q;

    // Head flags with deferred C/V resolved against the current SR
    always_comb begin
        head_flags         = '0;
        head_flags[FLAG_Z] = meta_q[0].z;
        head_flags[FLAG_N] = meta_q[0].n;
        head_flags[FLAG_C] = meta_q[0].keep_cv ? sr_q[FLAG_C] : meta_q[0].c;
        head_flags[FLAG_V] = meta_q[0].keep_cv ? sr_q[FLAG_V] : meta_q[0].v;
    end

    // Occupancy FSM and slot movement; a new entry goes to the head when the
    // head is free or retiring this cycle, otherwise into the skid slot
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        meta_d  = meta_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    data_d[0] = X;
                    meta_d[0] = in_meta;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && retire) begin
                    data_d[0] = X;
                    meta_d[0] = in_meta;
                end else if (accept) begin
                    data_d[1] = X;
                    meta_d[1] = in_meta;
                    state_d   = ST_FULL;
                end else if (retire) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (retire) begin
                    data_d[0] = data_q[1];
                    meta_d[0] = meta_q[1];
                    state_d   = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    // Status register takes the resolved head flags when a writing entry retires
    always_comb begin
        sr_d = sr_q;
        if (retire && meta_q[0].flag_we) begin
            sr_d = head_flags;
        end
    end

    // State, storage and SR registers; reset discards all in-flight entries
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            sr_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                meta_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            sr_q       <= sr_d;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= data_d[i];
                meta_q[i] <= meta_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: two instances (logical ops clear C/V, and
// logical ops keep C/V) share one stimulus stream; a queue-based model
// predicts handshake, data, flags and SR for both every cycle.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] X;
    logic        CIN_ALU, VIN_ALU, IS_ARITH, FLAG_WE, in_valid, out_ready;

    logic        in_ready_c, out_valid_c, in_ready_k, out_valid_k;
    logic [15:0] r_c, r_k;
    logic [3:0]  flags_c, flags_k, sr_c, sr_k;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(16), .LOGIC_CLR_CV(1'b1)) u_dut_clr (
        .clk(clk), .reset(reset), .X(X), .CIN_ALU(CIN_ALU), .VIN_ALU(VIN_ALU),
        .IS_ARITH(IS_ARITH), .FLAG_WE(FLAG_WE), .in_valid(in_valid),
        .in_ready(in_ready_c), .R(r_c), .FLAGS(flags_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .SR(sr_c)
    );

    alu_result_stage #(.WIDTH(16), .LOGIC_CLR_CV(1'b0)) u_dut_keep (
        .clk(clk), .reset(reset), .X(X), .CIN_ALU(CIN_ALU), .VIN_ALU(VIN_ALU),
        .IS_ARITH(IS_ARITH), .FLAG_WE(FLAG_WE), .in_valid(in_valid),
        .in_ready(in_ready_k), .R(r_k), .FLAGS(flags_k), .out_valid(out_valid_k),
        .out_ready(out_ready), .SR(sr_k)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] x;
        bit          arith;
        bit          cin;
        bit          vin;
        bit          we;
    } txn_t;

    txn_t       q_m[$];
    logic [3:0] sr_m[2];     // [0] clearing variant, [1] keeping variant
    bit         rdy_m;
    bit         last_acc;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [3:0] exp_flags(txn_t t, logic [3:0] sr, bit clr);
        bit c, v;
        if (t.arith) begin
            c = t.cin; v = t.vin;
        end else if (clr) begin
            c = 1'b0; v = 1'b0;
        end else begin
            c = sr[1]; v = sr[0];
        end
        return {t.x == 16'h0000, t.x[15], c, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("in_ready_c",  32'(in_ready_c),  32'(rdy_m));
        check("in_ready_k",  32'(in_ready_k),  32'(rdy_m));
        check("out_valid_c", 32'(out_valid_c), 32'(q_m.size() > 0));
        check("out_valid_k", 32'(out_valid_k), 32'(q_m.size() > 0));
        if (q_m.size() > 0) begin
            check("R_c",     32'(r_c),     32'(q_m[0].x));
            check("R_k",     32'(r_k),     32'(q_m[0].x));
            check("FLAGS_c", 32'(flags_c), 32'(exp_flags(q_m[0], sr_m[0], 1'b1)));
            check("FLAGS_k", 32'(flags_k), 32'(exp_flags(q_m[0], sr_m[1], 1'b0)));
        end
        check("SR_c", 32'(sr_c), 32'(sr_m[0]));
        check("SR_k", 32'(sr_k), 32'(sr_m[1]));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        bit acc, ret;
        txn_t t;
        @(posedge clk);
        if (reset) begin
            q_m.delete();
            sr_m[0] = 4'h0;
            sr_m[1] = 4'h0;
            rdy_m   = 1'b1;
            last_acc = 1'b0;
        end else begin
            acc = in_valid && rdy_m;
            ret = (q_m.size() > 0) && out_ready;
            if (ret) begin
                if (q_m[0].we) begin
                    sr_m[0] = exp_flags(q_m[0], sr_m[0], 1'b1);
                    sr_m[1] = exp_flags(q_m[0], sr_m[1], 1'b0);
                end
                void'(q_m.pop_front());
            end
            if (acc) begin
                t.x = X; t.arith = IS_ARITH; t.cin = CIN_ALU; t.vin = VIN_ALU; t.we = FLAG_WE;
                q_m.push_back(t);
            end
            rdy_m    = (q_m.size() < 2);
            last_acc = acc;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [15:0] x, input bit arith, input bit cin,
                         input bit vin, input bit we, input bit valid);
        X = x; IS_ARITH = arith; CIN_ALU = cin; VIN_ALU = vin; FLAG_WE = we; in_valid = valid;
    endtask

    logic [15:0] a_v, b_v;
    int          cnt_valid, cnt_nrdy, waited;

    initial begin
        reset = 1'b1; out_ready = 1'b1;
        drive(16'h0, 0, 0, 0, 0, 0);
        rdy_m = 1'b1; sr_m[0] = 4'h0; sr_m[1] = 4'h0; last_acc = 1'b0;

        // reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_R",     32'(r_c),     32'h0);
        check("rst_FLAGS", 32'(flags_c), 32'h0);
        check("rst_SR",    32'(sr_k),    32'h0);

        // single XOR result
        a_v = 16'hA5A5; b_v = 16'h5A5A;
        drive(a_v ^ b_v, 0, 1, 1, 1, 1);
        tick();
        check("xor_R",     32'(r_c),     32'hFFFF);
        check("xor_FLAGS", 32'(flags_c), 32'h4);
        drive(16'h0, 0, 0, 0, 0, 0);
        tick();
        check("xor_SR", 32'(sr_c), 32'h4);

        // zero result from the adder
        drive(16'h0000, 1, 1, 0, 1, 1);
        tick();
        check("zero_FLAGS", 32'(flags_k), 32'hA);
        drive(16'h0, 0, 0, 0, 0, 0);
        tick();
        check("zero_SR", 32'(sr_c), 32'hA);

        // backpressure and skid
        out_ready = 1'b0;
        drive(16'h0001, 1, 0, 0, 1, 1); tick();
        drive(16'h0002, 1, 0, 0, 1, 1); tick();
        check("bp_in_ready_low", 32'(in_ready_c), 32'h0);
        drive(16'h0003, 0, 0, 0, 1, 1); tick(); tick();
        check("bp_R_held", 32'(r_c), 32'h0001);
        out_ready = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!last_acc && waited < 10);
        check("bp_third_accepted", 32'(last_acc), 32'h1);
        drive(16'h0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // full throughput
        cnt_valid = 0; cnt_nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            drive(16'(16'h1000 + i), 0, 0, 0, 1, 1);
            tick();
            if (out_valid_c) cnt_valid++;
            if (!in_ready_c) cnt_nrdy++;
        end
        drive(16'h0, 0, 0, 0, 0, 0);
        repeat (2) begin
            tick();
            if (out_valid_c) cnt_valid++;
        end
        check("tput_valid_cycles", 32'(cnt_valid), 32'd8);
        check("tput_ready_drops",  32'(cnt_nrdy),  32'd0);

        // C/V chaining through SR for logical ops
        drive(16'h1234, 1, 1, 1, 1, 1); tick();
        drive(16'h8000, 0, 0, 0, 1, 1); tick();
        drive(16'h0, 0, 0, 0, 0, 0);
        check("chain_FLAGS_k", 32'(flags_k), 32'h7);
        check("chain_FLAGS_c", 32'(flags_c), 32'h4);
        tick();
        check("chain_SR_k", 32'(sr_k), 32'h7);

        // reset while full
        out_ready = 1'b0;
        drive(16'h00AA, 1, 1, 1, 1, 1); tick();
        drive(16'h00BB, 1, 1, 1, 1, 1); tick();
        out_ready = 1'b1; reset = 1'b1;
        drive(16'h00CC, 1, 1, 1, 1, 1);
        tick();
        reset = 1'b0;
        drive(16'h0, 0, 0, 0, 0, 0);
        check("mrst_out_valid", 32'(out_valid_c), 32'h0);
        check("mrst_SR",        32'(sr_k),        32'h0);
        check("mrst_in_ready",  32'(in_ready_c),  32'h1);
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            X = 16'($urandom);
            if ($urandom_range(0, 7) == 0) X = 16'h0000;
            if ($urandom_range(0, 7) == 0) X = 16'h8000;
            IS_ARITH  = 1'($urandom_range(0, 1));
            CIN_ALU   = 1'($urandom_range(0, 1));
            VIN_ALU   = 1'($urandom_range(0, 1));
            FLAG_WE   = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
